// File: rtl/rf_arb_pkg.sv
// Shared defaults, limits and FSM encoding for the register-file access arbiter.
package rf_arb_pkg;

    localparam int RF_AW_DEF    = 3;
    localparam int RF_DW_DEF    = 8;
    localparam int NREQ_MAX     = 4;
    localparam int MAX_HOLD_DEF = 16;
    localparam int HOLD_CNT_W   = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    // Index of the set bit in a one-hot vector (0 when empty).
    function automatic int onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) return i;
        end
        return 0;
    endfunction

endpackage

// File: rtl/rf_access_arbiter_if.sv
// Requester-side and register-file-side bus of the arbiter; slave = arbiter, master = surroundings.
interface rf_access_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RF_AW_DEF,
    parameter int DW   = RF_DW_DEF
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic [NREQ*AW-1:0] q_R_Addr;
    logic [NREQ*AW-1:0] q_W_Addr;
    logic [NREQ-1:0]    q_R_en;
    logic [NREQ-1:0]    q_W_en;
    logic [NREQ*DW-1:0] q_W_Data;
    logic [DW-1:0]      R_Data;
    logic               busy;
    logic [AW-1:0]      rf_R_Addr;
    logic [AW-1:0]      rf_W_Addr;
    logic               rf_R_en;
    logic               rf_W_en;
    logic [DW-1:0]      rf_W_Data;
    logic [DW-1:0]      rf_R_Data;

    modport slave (
        input  req, lock, q_R_Addr, q_W_Addr, q_R_en, q_W_en, q_W_Data, rf_R_Data,
        output gnt, busy, R_Data, rf_R_Addr, rf_W_Addr, rf_R_en, rf_W_en, rf_W_Data
    );

    modport master (
        output req, lock, q_R_Addr, q_W_Addr, q_R_en, q_W_en, q_W_Data, rf_R_Data,
        input  gnt, busy, R_Data, rf_R_Addr, rf_W_Addr, rf_R_en, rf_W_en, rf_W_Data
    );

endinterface

// File: rtl/rf_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first candidate strictly after 'last', wrapping around.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    input  logic [NREQ-1:0] excl,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    logic [NREQ-1:0] cand;
    assign cand = req & ~excl;

    always_comb begin
        int            k;
        logic [IW-1:0] k_idx;
        winner = '0;
        valid  = 1'b0;
        k      = 0;
        k_idx  = '0;
        for (int o = 1; o <= NREQ; o++) begin
            k     = (int'(last) + o) % NREQ;
            k_idx = IW'(k);
            if (!valid && cand[k_idx]) begin
                winner[k_idx] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one register file between NREQ requesters with lock-based hold.
// Optional bounded-hold preemption of unlocked owners: define RF_ARB_PREEMPT_EN.
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int AW       = RF_AW_DEF,
    parameter int DW       = RF_DW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                Clk,
    input  logic                Rst,
    rf_access_arbiter_if.slave  bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_reg, state_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [IW-1:0]   owner_reg, owner_next;
    logic [IW-1:0]   last_reg, last_next;
    logic            busy_reg;

    logic [NREQ-1:0] pick_excl;
    logic [NREQ-1:0] pick_onehot;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            hold;
    logic            others;
    logic            preempt;

    logic [AW-1:0] r_addr_arr [NREQ];
    logic [AW-1:0] w_addr_arr [NREQ];
    logic [DW-1:0] w_data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_split
            assign r_addr_arr[gi] = bus.q_R_Addr[gi*AW +: AW];
            assign w_addr_arr[gi] = bus.q_W_Addr[gi*AW +: AW];
            assign w_data_arr[gi] = bus.q_W_Data[gi*DW +: DW];
        end
    endgenerate

    // While granted, the owner sorts last in round-robin order and is excluded outright.
    assign pick_excl = (state_reg == GRANTED) ? gnt_reg : '0;
    assign pick_idx  = IW'(onehot_to_idx(NREQ_MAX'(pick_onehot)));
    assign hold      = bus.req[owner_reg] | bus.lock[owner_reg];
    assign others    = |(bus.req & ~gnt_reg);

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (bus.req),
        .last   (last_reg),
        .excl   (pick_excl),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

`ifdef RF_ARB_PREEMPT_EN
    logic [HOLD_CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic                  contended;

    assign contended = ~bus.lock[owner_reg] & others;
    // The cycle whose contention brings the count to MAX_HOLD is the one that hands over.
    assign preempt   = (state_reg == GRANTED) && contended &&
                       (hold_cnt_reg >= HOLD_CNT_W'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (gnt_next != gnt_reg) begin
            hold_cnt_next = '0;
        end else if ((state_reg == GRANTED) && contended && (hold_cnt_reg != '1)) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) hold_cnt_reg <= '0;
        else     hold_cnt_reg <= hold_cnt_next;
    end
`else
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD == 0);
    assign preempt         = 1'b0;
`endif

    always_comb begin
        logic take;
        state_next = state_reg;
        gnt_next   = gnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) take = 1'b1;
            end
            GRANTED: begin
                if (!hold || preempt) begin
                    if (pick_valid) begin
                        take = 1'b1;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
        if (take) begin
            state_next = GRANTED;
            gnt_next   = pick_onehot;
            owner_next = pick_idx;
            last_next  = pick_idx;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            owner_reg <= '0;
            last_reg  <= IW'(NREQ - 1);
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
            busy_reg  <= |gnt_next;
        end
    end

    always_comb begin
        bus.rf_R_Addr = '0;
        bus.rf_W_Addr = '0;
        bus.rf_W_Data = '0;
        bus.rf_R_en   = 1'b0;
        bus.rf_W_en   = 1'b0;
        if (|gnt_reg) begin
            bus.rf_R_Addr = r_addr_arr[owner_reg];
            bus.rf_W_Addr = w_addr_arr[owner_reg];
            bus.rf_W_Data = w_data_arr[owner_reg];
            bus.rf_R_en   = bus.q_R_en[owner_reg];
            bus.rf_W_en   = bus.q_W_en[owner_reg];
        end
    end

    assign bus.gnt    = gnt_reg;
    assign bus.busy   = busy_reg;
    assign bus.R_Data = bus.rf_R_Data;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: vector table, directed corner sequences and a randomized run vs. a reference model.
module tb_rf_access_arbiter;

    localparam int NR   = 2;
    localparam int AWT  = 3;
    localparam int DWT  = 8;
    localparam int MAXH = 4;
`ifdef RF_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rf_access_arbiter_if #(.NREQ(NR), .AW(AWT), .DW(DWT)) bus ();

    rf_access_arbiter #(
        .NREQ     (NR),
        .AW       (AWT),
        .DW       (DWT),
        .MAX_HOLD (MAXH)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: write on the edge, asynchronous read of the stored (old) contents.
    logic [DWT-1:0] mem [8];
    always @(posedge clk) begin
        if (bus.rf_W_en) mem[bus.rf_W_Addr] <= bus.rf_W_Data;
    end
    assign bus.rf_R_Data = mem[bus.rf_R_Addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                          input logic [1:0] ren, input logic [1:0] wen);
        rst        = r;
        bus.req    = rq;
        bus.lock   = lk;
        bus.q_R_en = ren;
        bus.q_W_en = wen;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] lock;
        logic [1:0] ren;
        logic [1:0] wen;
        logic [1:0] exp_gnt;
        logic       exp_busy;
        logic       exp_wen;
        logic       exp_ren;
    } vec_t;

    vec_t vecs [18];

    // Reference model: owner = -1 means nobody holds the file.
    int m_owner, m_last, m_cnt;

    function automatic int rr(input int last_i, input int excl, input logic [1:0] r);
        for (int o = 1; o <= NR; o++) begin
            int k;
            k = (last_i + o) % NR;
            if (k != excl && r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        bit hold, others, contended, pre;
        if (rst) begin
            m_owner = -1; m_last = NR - 1; m_cnt = 0;
        end else if (m_owner < 0) begin
            w = rr(m_last, -1, bus.req);
            if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 0; end
        end else begin
            hold   = bus.req[m_owner] || bus.lock[m_owner];
            others = 1'b0;
            for (int k = 0; k < NR; k++) if (k != m_owner && bus.req[k]) others = 1'b1;
            contended = !bus.lock[m_owner] && others;
            pre       = PREEMPT && contended && (m_cnt + 1 >= MAXH);
            if (hold && !pre) begin
                if (contended) m_cnt++;
            end else begin
                w = rr(m_owner, m_owner, bus.req);
                if (w >= 0) begin m_owner = w; m_last = w; end
                else m_owner = -1;
                m_cnt = 0;
            end
        end
    endtask

    initial begin
        int old5, sw_at, exp_sw;
        int e_raddr, e_waddr, e_wdata, e_ren, e_wen;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) mem[i] = DWT'(i * 17);
        set_in(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        bus.q_R_Addr = '0; bus.q_W_Addr = '0; bus.q_W_Data = '0;

        //            rst  req    lock   ren    wen    gnt    busy wen  ren
        vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 2'b10, 2'b10, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            set_in(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].ren, vecs[i].wen);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].exp_gnt));
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_rf_W_en", i), 32'(bus.rf_W_en), 32'(vecs[i].exp_wen));
            chk($sformatf("vec%0d_rf_R_en", i), 32'(bus.rf_R_en), 32'(vecs[i].exp_ren));
            $display("vec %0d: rst=%b req=%b lock=%b -> gnt=%b busy=%b", i, rst, bus.req, bus.lock,
                     bus.gnt, bus.busy);
        end

        // Owner 1 writes address 3 while requester 0 tries to write address 5.
        @(negedge clk); set_in(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk); set_in(1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
        @(posedge clk); #1; chk("wr_grant", 32'(bus.gnt), 32'h2);
        @(negedge clk);
        old5 = int'(mem[5]);
        bus.q_W_Addr = {3'd3, 3'd5};
        bus.q_W_Data = {8'h5A, 8'hFF};
        bus.q_W_en   = 2'b11;
        @(posedge clk); #1;
        chk("wr_addr3", 32'(mem[3]), 32'h5A);
        chk("wr_addr5_untouched", 32'(mem[5]), 32'(old5));
        $display("write: owner1 addr3=5a, non-owner addr5 ignored");
        @(negedge clk);
        bus.q_W_en = 2'b00; bus.q_R_en = 2'b10; bus.q_R_Addr = {3'd3, 3'd0};
        #1; chk("rd_addr3", 32'(bus.R_Data), 32'h5A);
        @(negedge clk);
        bus.q_W_en = 2'b10; bus.q_W_Data = {8'h77, 8'h00};
        #1; chk("rw_same_old", 32'(bus.R_Data), 32'h5A);
        @(posedge clk); #1; chk("rw_same_new", 32'(bus.R_Data), 32'h77);
        $display("read/write same address: old then new value");

        // Lock holds ownership with req dropped while the other side waits.
        @(negedge clk); set_in(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        @(negedge clk); set_in(1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
        @(posedge clk); #1; chk("lock_grant0", 32'(bus.gnt), 32'h1);
        @(negedge clk); set_in(1'b0, 2'b10, 2'b01, 2'b00, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1; chk($sformatf("lock_hold%0d", i), 32'(bus.gnt), 32'h1);
        end
        @(negedge clk); bus.lock = 2'b00;
        @(posedge clk); #1; chk("lock_release", 32'(bus.gnt), 32'h2);
        $display("lock: held 5 cycles then handed to requester 1");

        // Unlocked owner under contention: preempted after MAXH contended cycles only if enabled.
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk); set_in(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
            @(negedge clk); set_in(1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
            @(posedge clk); #1;
            @(negedge clk); set_in(1'b0, 2'b11, (pass == 1) ? 2'b01 : 2'b00, 2'b00, 2'b00);
            sw_at = -1;
            for (int i = 1; i <= 10; i++) begin
                @(posedge clk); #1;
                if (bus.gnt == 2'b10 && sw_at < 0) sw_at = i;
            end
            exp_sw = (PREEMPT && pass == 0) ? MAXH : -1;
            chk($sformatf("hold_switch_pass%0d", pass), 32'(sw_at), 32'(exp_sw));
            $display("hold pass %0d: switch after %0d edges", pass, sw_at);
        end

        // Randomized traffic against the reference model.
        @(negedge clk); set_in(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        @(posedge clk); model_step(); #1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            rst = ($urandom_range(63) == 0);
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(4) == 0) bus.req[k] = ~bus.req[k];
                bus.lock[k] = ($urandom_range(6) == 0);
            end
            bus.q_R_en   = 2'($urandom);
            bus.q_W_en   = 2'($urandom);
            bus.q_R_Addr = 6'($urandom);
            bus.q_W_Addr = 6'($urandom);
            bus.q_W_Data = 16'($urandom);
            #1;
            e_raddr = 0; e_waddr = 0; e_wdata = 0; e_ren = 0; e_wen = 0;
            if (m_owner >= 0) begin
                e_raddr = int'((bus.q_R_Addr >> (m_owner * AWT)) & 6'h7);
                e_waddr = int'((bus.q_W_Addr >> (m_owner * AWT)) & 6'h7);
                e_wdata = int'((bus.q_W_Data >> (m_owner * DWT)) & 16'hFF);
                e_ren   = int'(bus.q_R_en[m_owner]);
                e_wen   = int'(bus.q_W_en[m_owner]);
            end
            chk("rnd_gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
            chk("rnd_busy", 32'(bus.busy), 32'(m_owner >= 0));
            chk("rnd_rf_R_en", 32'(bus.rf_R_en), 32'(e_ren));
            chk("rnd_rf_W_en", 32'(bus.rf_W_en), 32'(e_wen));
            chk("rnd_rf_R_Addr", 32'(bus.rf_R_Addr), 32'(e_raddr));
            chk("rnd_rf_W_Addr", 32'(bus.rf_W_Addr), 32'(e_waddr));
            chk("rnd_rf_W_Data", 32'(bus.rf_W_Data), 32'(e_wdata));
            chk("rnd_R_Data", 32'(bus.R_Data), 32'(mem[e_raddr]));
            $display("rnd %0d: rst=%b req=%b lock=%b gnt=%b owner=%0d", t, rst, bus.req, bus.lock,
                     bus.gnt, m_owner);
            @(posedge clk); model_step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Shares one 8-entry x 8-bit register file (one read port, one write port) between NREQ requesters, e.g. the insertion-sort engine and a host load/readback port.
- Grants are round-robin. Ownership is held while the owner keeps req or lock high, so multi-cycle read-compare-write sequences are never interleaved.
- Muxes the owner's address, enable and data strobes onto the register file and returns read data to every requester.

Parameters:
- NREQ, 2, number of requesters (2..4)
- AW, 3, register file address width
- DW, 8, register file data width
- MAX_HOLD, 16, cycles an unlocked owner may hold the grant while others wait (used only with the optional feature)

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester access request
- lock  in  NREQ  per-requester ownership hold; honoured only for the current owner
- gnt  out  NREQ  one-hot registered grant
- q_R_Addr  in  NREQ*AW  requester read addresses, flattened, requester k at [k*AW +: AW]
- q_W_Addr  in  NREQ*AW  requester write addresses, flattened
- q_R_en  in  NREQ  requester read enables
- q_W_en  in  NREQ  requester write enables
- q_W_Data  in  NREQ*DW  requester write data, flattened
- R_Data  out  DW  read data broadcast to all requesters (rf_R_Data passed through)
- rf_R_Addr  out  AW  to register file
- rf_W_Addr  out  AW  to register file
- rf_R_en  out  1  to register file
- rf_W_en  out  1  to register file
- rf_W_Data  out  DW  to register file
- rf_R_Data  in  DW  from register file
- busy  out  1  registered; high whenever any gnt bit is high

Behaviour:
- Reset (Rst high at a rising edge):
  - gnt=0, busy=0, state=IDLE, owner index=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - A reset mid-transaction drops the grant on that edge; the requester must re-request.
- FSM states: IDLE, GRANTED.
- IDLE:
  - If any req is high, pick the first requester after last in circular order.
  - On the next edge: gnt gets that one-hot bit, owner and last are updated, state becomes GRANTED.
  - Latency: req sampled high at edge t gives gnt high after edge t.
  - If no req is high, stay in IDLE.
- GRANTED:
  - Hold condition is req[owner] | lock[owner].
  - While the hold condition is true: keep ownership and drive rf_* from the owner's q_* signals combinationally. The register file sees the owner's strobes in the same cycle.
  - When the hold condition is false and another req is pending: hand over on the next edge directly to the round-robin winner, with no dead cycle.
  - When the hold condition is false and no other req is pending: go to IDLE and clear gnt.
- Strobe gating:
  - rf_R_en and rf_W_en are forced to 0 whenever gnt is 0.
  - Non-owner strobes are always ignored.
  - Addresses and data default to 0 when there is no owner.
- Boundary conditions:
  - Simultaneous requests resolve round-robin.
  - A lone requester that drops req for one cycle and re-raises it is re-granted after a single IDLE cycle.
  - lock from a non-owner has no effect.
  - Owner writing and reading the same address in one cycle: R_Data shows the old value (register file semantics, not bypassed).
- busy equals the OR of gnt.

Optional Feature:
- Macro: RF_ARB_PREEMPT_EN.
- Defined:
  - An 8-bit hold counter clears on every grant change.
  - It increments each GRANTED cycle where lock[owner]=0 and another req is high.
  - At MAX_HOLD, the grant moves to the next round-robin winner on the following edge.
  - Owners with lock high are never preempted.
- Undefined: no counter; the grant is held indefinitely while req[owner] is high.

Decomposition:
- Package rf_arb_pkg holds the AW/DW defaults, the NREQ limit, the state encoding (IDLE=0, GRANTED=1) and the MAX_HOLD default.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req vector, last index, exclude-mask.
  - Outputs: one-hot winner and a valid bit.

Test Plan:
- Rst high for 2 cycles, then release with req=2'b11 -> after the first edge gnt=2'b01; requester 0 then drops req -> next edge gnt=2'b10 with no idle cycle.
- Requester 1 owns the grant and writes W_Addr=3, W_Data=8'h5A; requester 0 asserts W_en concurrently -> only address 3 changes; a later read of address 3 returns 8'h5A.
- Owner 0 holds lock=1, req=0 for 5 cycles while req[1]=1 -> gnt stays 2'b01 throughout; lock drops -> gnt=2'b10 next edge.
- Assert Rst while gnt=2'b10 mid-sequence -> gnt=0, busy=0 after the edge; the next arbitration with req=2'b11 grants requester 0.
- No requests -> rf_R_en=0 and rf_W_en=0 even if q_W_en=2'b11.
- With RF_ARB_PREEMPT_EN, MAX_HOLD=4: owner 0 holds req with lock=0 while req[1]=1 -> gnt switches to 2'b10 exactly 4 cycles after the contention starts; the same case with lock=1 -> no switch.
